// File: rtl/seq_window_checker.sv
// seq_window_checker: multi-channel runtime checker for the bounded implication
//   ante |-> ##[MIN_DLY:MAX_DLY] cons   with a per-channel disable-iff (dis).
//
// Ports:
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous active-high reset
//   en_i             global enable; low blocks new attempts only
//   clr_i            clears fail counters, err and first_fail_ch
//   ante_i[NUM_CH]   per-channel antecedent
//   cons_i[NUM_CH]   per-channel consequent
//   dis_i[NUM_CH]    per-channel abort of all outstanding attempts
//   pass_o[NUM_CH]   registered pulse: at least one attempt satisfied
//   fail_o[NUM_CH]   registered pulse: an attempt expired unsatisfied
//   pend_o[NUM_CH]   registered: attempts outstanding after the update
//   fail_cnt_o       saturating failure counters, channel i at [i*CNT_W +: CNT_W]
//   err_o            sticky: any failure since reset/clr
//   first_fail_ch_o  lowest-index channel of the first failure since reset/clr
module seq_window_checker #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 3,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic [NUM_CH-1:0]       ante_i,
    input  logic [NUM_CH-1:0]       cons_i,
    input  logic [NUM_CH-1:0]       dis_i,
    output logic [NUM_CH-1:0]       pass_o,
    output logic [NUM_CH-1:0]       fail_o,
    output logic [NUM_CH-1:0]       pend_o,
    output logic [NUM_CH*CNT_W-1:0] fail_cnt_o,
    output logic                    err_o,
    output logic [CH_W-1:0]         first_fail_ch_o
);

    if (NUM_CH < 1 || MAX_DLY < 1 || MIN_DLY > MAX_DLY) begin : g_bad_params
        $error("seq_window_checker: need NUM_CH>=1, MAX_DLY>=1 and MIN_DLY<=MAX_DLY");
    end

    // p_q[c][k] = 1: an unsatisfied attempt on channel c was launched k cycles ago.
    logic [NUM_CH-1:0][MAX_DLY:1]   p_q, p_d;
    logic [NUM_CH-1:0]              pass_q, pass_d;
    logic [NUM_CH-1:0]              fail_q, fail_d;
    logic [NUM_CH-1:0]              pend_q, pend_d;
    logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic                           err_q, err_d;
    logic [CH_W-1:0]                ffc_q, ffc_d;

    // Attempt ageing: v = live attempts by age (age 0 = launched now),
    // h = attempts satisfied this cycle, r = survivors.
    always_comb begin : attempt_update
        logic [MAX_DLY:0] v;
        logic [MAX_DLY:0] h;
        logic [MAX_DLY:0] r;
        p_d    = '0;
        pass_d = '0;
        fail_d = '0;
        pend_d = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            v    = '0;
            h    = '0;
            r    = '0;
            v[0] = ante_i[c] & en_i;
            for (int k = 1; k <= int'(MAX_DLY); k++) begin
                v[k] = p_q[c][k];
            end
            // One cons cycle satisfies every attempt whose window covers it.
            for (int k = 0; k <= int'(MAX_DLY); k++) begin
                h[k] = v[k] & cons_i[c] & (k >= int'(MIN_DLY));
            end
            r = v & ~h;
            // dis aborts silently: state, pass and fail stay cleared.
            if (!dis_i[c]) begin
                for (int k = 0; k < int'(MAX_DLY); k++) begin
                    p_d[c][k+1] = r[k];
                end
                pass_d[c] = |h;
                fail_d[c] = r[MAX_DLY];
            end
            pend_d[c] = |p_d[c];
        end
    end

    // Statistics: clr behaves as if the registers were zero this cycle, so a
    // coinciding failure is still recorded.
    always_comb begin : stats_update
        cnt_d = clr_i ? '0 : cnt_q;
        err_d = clr_i ? 1'b0 : err_q;
        ffc_d = clr_i ? '0 : ffc_q;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (fail_d[c] && (cnt_d[c] != {CNT_W{1'b1}})) begin
                cnt_d[c] = cnt_d[c] + 1'b1;
            end
        end
        if (!err_d && (|fail_d)) begin
            // Descending scan so the lowest failing index wins.
            for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
                if (fail_d[c]) begin
                    ffc_d = CH_W'(c);
                end
            end
        end
        err_d = err_d | (|fail_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q    <= '0;
            pass_q <= '0;
            fail_q <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            ffc_q  <= '0;
        end else begin
            p_q    <= p_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            ffc_q  <= ffc_d;
        end
    end

    assign pass_o          = pass_q;
    assign fail_o          = fail_q;
    assign pend_o          = pend_q;
    assign fail_cnt_o      = cnt_q;
    assign err_o           = err_q;
    assign first_fail_ch_o = ffc_q;

endmodule

// File: tb/tb_seq_window_checker.sv
// Testbench for seq_window_checker (NUM_CH=2, MIN_DLY=1, MAX_DLY=3, CNT_W=4).
// Driver issues stimulus on the falling edge and pushes the reference model's
// expected post-edge outputs; a monitor pops and compares after each rising edge.
module tb_seq_window_checker;

    localparam int NUM_CH  = 2;
    localparam int MIN_DLY = 1;
    localparam int MAX_DLY = 3;
    localparam int CNT_W   = 4;
    localparam int CH_W    = 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b1;
    logic                    clr = 1'b0;
    logic [NUM_CH-1:0]       ante = '0;
    logic [NUM_CH-1:0]       cons = '0;
    logic [NUM_CH-1:0]       dis = '0;
    logic [NUM_CH-1:0]       pass;
    logic [NUM_CH-1:0]       fail;
    logic [NUM_CH-1:0]       pend;
    logic [NUM_CH*CNT_W-1:0] fail_cnt;
    logic                    err;
    logic [CH_W-1:0]         first_fail_ch;

    seq_window_checker #(
        .NUM_CH (NUM_CH),
        .MIN_DLY(MIN_DLY),
        .MAX_DLY(MAX_DLY),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_i           (en),
        .clr_i          (clr),
        .ante_i         (ante),
        .cons_i         (cons),
        .dis_i          (dis),
        .pass_o         (pass),
        .fail_o         (fail),
        .pend_o         (pend),
        .fail_cnt_o     (fail_cnt),
        .err_o          (err),
        .first_fail_ch_o(first_fail_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pass;
        logic [1:0] fail;
        logic [1:0] pend;
        logic [3:0] c0;
        logic [3:0] c1;
        logic       err;
        logic       ff;
    } exp_t;

    typedef struct {
        int ch;
        int age;
    } att_t;

    exp_t sb[$];
    att_t atts[$];     // outstanding attempts: channel and age in cycles
    int   m_cnt[NUM_CH];
    bit   m_err;
    int   m_ff;
    int   checks = 0;
    int   errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endfunction

    // Reference model: attempts are a list of (channel, age) records.
    task automatic model(input logic [1:0] a, input logic [1:0] c, input logic [1:0] d,
                         input logic e, input logic cl, input logic r, output exp_t x);
        att_t       nxt[$];
        logic [1:0] fl;
        x  = '0;
        fl = '0;
        if (r) begin
            atts.delete();
            for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
            m_err = 0;
            m_ff  = 0;
            return;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (a[ch] && e && !d[ch]) atts.push_back('{ch, 0});
        end
        foreach (atts[i]) begin
            if (d[atts[i].ch]) continue;
            if (c[atts[i].ch] && atts[i].age >= MIN_DLY) x.pass[atts[i].ch] = 1'b1;
            else if (atts[i].age == MAX_DLY) fl[atts[i].ch] = 1'b1;
            else nxt.push_back('{atts[i].ch, atts[i].age + 1});
        end
        atts = nxt;
        foreach (atts[i]) x.pend[atts[i].ch] = 1'b1;
        if (cl) begin
            for (int ch = 0; ch < NUM_CH; ch++) m_cnt[ch] = 0;
            m_err = 0;
            m_ff  = 0;
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (fl[ch]) begin
                if (m_cnt[ch] < CNT_MAX) m_cnt[ch]++;
                if (!m_err) begin
                    m_err = 1;
                    m_ff  = ch;
                end
            end
        end
        x.fail = fl;
        x.c0   = 4'(m_cnt[0]);
        x.c1   = 4'(m_cnt[1]);
        x.err  = m_err;
        x.ff   = 1'(m_ff);
    endtask

    task automatic step(input logic [1:0] a, input logic [1:0] c, input logic [1:0] d,
                        input logic e = 1'b1, input logic cl = 1'b0, input logic r = 1'b0);
        exp_t x;
        @(negedge clk);
        ante = a;
        cons = c;
        dis  = d;
        en   = e;
        clr  = cl;
        rst  = r;
        model(a, c, d, e, cl, r, x);
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 2'b00);
    endtask

    // Monitor: outputs are valid every cycle once stimulus has been issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pass", 32'(pass), 32'(e.pass));
                check("fail", 32'(fail), 32'(e.fail));
                check("pend", 32'(pend), 32'(e.pend));
                check("fail_cnt0", 32'(fail_cnt[3:0]), 32'(e.c0));
                check("fail_cnt1", 32'(fail_cnt[7:4]), 32'(e.c1));
                check("err", 32'(err), 32'(e.err));
                check("first_fail_ch", 32'(first_fail_ch), 32'(e.ff));
            end
        end
    end

    initial begin
        // Reset
        step(2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        idle(2);
        // Basic pass: cons at age 2
        step(2'b01, 2'b00, 2'b00); idle(1); step(2'b00, 2'b01, 2'b00); idle(3);
        // Expiry on ch1
        step(2'b10, 2'b00, 2'b00); idle(6);
        // Overlap: one cons covers two attempts
        step(2'b01, 2'b00, 2'b00); step(2'b01, 2'b00, 2'b00); step(2'b00, 2'b01, 2'b00);
        idle(4);
        // Overlap: cons at age 1 of first attempt and age 0 of second
        step(2'b01, 2'b00, 2'b00); step(2'b01, 2'b01, 2'b00); idle(6);
        // Window edges: cons only at age 0 -> fail; cons at age 3 -> pass
        step(2'b01, 2'b01, 2'b00); idle(5);
        step(2'b01, 2'b00, 2'b00); idle(2); step(2'b00, 2'b01, 2'b00); idle(2);
        // Disable mid-attempt, then launch on the dis-deassert cycle
        step(2'b01, 2'b00, 2'b00); idle(1); step(2'b00, 2'b00, 2'b01); idle(2);
        step(2'b01, 2'b00, 2'b01); step(2'b01, 2'b00, 2'b00); idle(5);
        // Simultaneous fails on both channels after clr
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b1); step(2'b11, 2'b00, 2'b00); idle(5);
        // Saturation: 20 failures on ch0
        for (int i = 0; i < 20; i++) step(2'b01, 2'b00, 2'b00);
        idle(5);
        // clr coinciding with a ch1 fail
        step(2'b10, 2'b00, 2'b00); idle(2); step(2'b00, 2'b00, 2'b00, 1'b1, 1'b1); idle(2);
        // en low: no launches, outstanding attempts still resolve
        step(2'b11, 2'b00, 2'b00); step(2'b11, 2'b00, 2'b00, 1'b0);
        step(2'b11, 2'b10, 2'b00, 1'b0); idle(4);
        // Reset with attempts pending
        step(2'b11, 2'b00, 2'b00); idle(1);
        step(2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1); idle(5);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] a, c, d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                a[ch] = ($urandom_range(99) < 40);
                c[ch] = ($urandom_range(99) < 30);
                d[ch] = ($urandom_range(99) < 5);
            end
            step(a, c, d, 1'($urandom_range(99) < 90), 1'($urandom_range(99) < 3),
                 1'($urandom_range(99) < 1));
        end
        idle(1);
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
